div_share_arbiter: RTL and testbench

//  Time-shares one div_32bit_4fp instance among N_REQ requesters in the tone-mapping path
//  (per-frame glE/aE stages that fire rarely). Round-robin arbitration, one divide in flight,

---
 rtl/div_share_arbiter_if.sv | 37 +++
 rtl/div_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : div_share_arbiter_if
// Description : Requester and divider bus of the shared-divider arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 32
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [N_REQ-1:0]   gnt;
    logic [W-1:0]       res;
    logic [N_REQ-1:0]   res_valid;
    logic               res_inv;
    logic               busy;
    logic [W-1:0]       div_A;
    logic [W-1:0]       div_B;
    logic               div_valid;
    logic [W-1:0]       div_out;
    logic               div_ready;
    logic               div_inv;
    logic               timeout_err;

    modport slave (
        input  req, a_in, b_in, div_out, div_ready, div_inv,
        output gnt, res, res_valid, res_inv, busy, div_A, div_B, div_valid, timeout_err
    );

    modport master (
        output req, a_in, b_in, div_out, div_ready, div_inv,
        input  gnt, res, res_valid, res_inv, busy, div_A, div_B, div_valid, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/div_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_share_arbiter
// Description : Round-robin time-sharing of one divider among N_REQ requesters.
//               Optional WAIT watchdog enabled by macro DIV_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module div_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    div_share_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if ((N_REQ < 2) || (N_REQ > 8) || (TIMEOUT < 2)) begin : g_param_check
        $error("div_share_arbiter: unsupported parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [W-1:0]    div_a_q, div_a_d;
    logic [W-1:0]    div_b_q, div_b_d;
    logic [W-1:0]    res_q, res_d;
    logic            res_inv_q, res_inv_d;
    logic [IW-1:0]   sel;
    logic            hit;
    logic [IW:0]     idx;
    logic [N_REQ-1:0] owner_oh;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif

    // Scan downward so the requester closest above rr_ptr is the last (winning) hit.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (IW+1)'(rr_ptr_q) + (IW+1)'(k);
            if (idx >= (IW+1)'(N_REQ)) begin
                idx = idx - (IW+1)'(N_REQ);
            end
            if (bus.req[idx[IW-1:0]]) begin
                sel = idx[IW-1:0];
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        res_d     = res_q;
        res_inv_d = res_inv_q;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        to_d      = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    owner_d = sel;
                    div_a_d = bus.a_in[int'(sel)*W +: W];
                    div_b_d = bus.b_in[int'(sel)*W +: W];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef DIV_ARB_TIMEOUT_EN
                cnt_d   = CW'(1);
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.div_ready) begin
                    res_d     = bus.div_out;
                    res_inv_d = bus.div_inv;
                    state_d   = S_DONE;
`ifdef DIV_ARB_TIMEOUT_EN
                    to_d      = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abort lands in DONE exactly TIMEOUT cycles after ISSUE.
                    res_d     = '0;
                    res_inv_d = 1'b1;
                    to_d      = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
`endif
                end
            end
            S_DONE: begin
                rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
                state_d  = S_IDLE;
`ifdef DIV_ARB_TIMEOUT_EN
                to_d     = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            res_q     <= '0;
            res_inv_q <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            res_q     <= res_d;
            res_inv_q <= res_inv_d;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            to_q      <= to_d;
`endif
        end
    end

    assign owner_oh      = N_REQ'(1) << owner_q;
    assign bus.gnt       = (state_q == S_ISSUE) ? owner_oh : '0;
    assign bus.res_valid = (state_q == S_DONE)  ? owner_oh : '0;
    assign bus.div_valid = (state_q == S_ISSUE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.div_A     = div_a_q;
    assign bus.div_B     = div_b_q;
    assign bus.res       = res_q;
    assign bus.res_inv   = res_inv_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign bus.timeout_err = (state_q == S_DONE) && to_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_share_arbiter
// Description : Directed bench for div_share_arbiter with an 8-cycle divider model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_share_arbiter;
    localparam int N_REQ = 4;
    localparam int W     = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_share_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

    div_share_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Divider model: ready 8 cycles after the valid cycle, OUT = (A<<4)/B.
    logic [7:0]  vpipe;
    logic [31:0] m_a, m_b;
    logic [35:0] m_q;
    logic        model_hang = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            m_a   <= '0;
            m_b   <= '0;
        end else begin
            vpipe <= {vpipe[6:0], bus.div_valid & ~model_hang};
            if (bus.div_valid) begin
                m_a <= bus.div_A;
                m_b <= bus.div_B;
            end
        end
    end
    assign m_q           = (m_b == 0) ? 36'd0 : ({m_a, 4'b0000} / {4'b0000, m_b});
    assign bus.div_out   = m_q[31:0];
    assign bus.div_inv   = (m_b == 0);
    assign bus.div_ready = vpipe[7];

    typedef struct {
        logic [3:0]        set;
        logic [3:0][31:0]  a;
        logic [3:0][31:0]  b;
        logic [3:0]        gnt;
        logic [31:0]       res;
        logic              inv;
    } vec_t;

    vec_t             tbl [12];
    logic [3:0][31:0] a_arr;
    logic [3:0][31:0] b_arr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] set, input logic [127:0] a,
                                input logic [127:0] b, input logic [3:0] gnt,
                                input logic [31:0] res, input logic inv);
        vec_t v;
        v.set = set; v.a = a; v.b = b; v.gnt = gnt; v.res = res; v.inv = inv;
        return v;
    endfunction

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == 0 && n < 30);
    endtask

    task automatic run_txn(input int r);
        int n;
        int own;
        for (int i = 0; i < 4; i++) begin
            if (tbl[r].set[i]) begin
                a_arr[i] = tbl[r].a[i];
                b_arr[i] = tbl[r].b[i];
            end
        end
        bus.a_in = a_arr;
        bus.b_in = b_arr;
        bus.req  = bus.req | tbl[r].set;
        wait_gnt(n);
        check($sformatf("gnt[%0d]", r), 32'(bus.gnt), 32'(tbl[r].gnt));
        check($sformatf("gnt_lat[%0d]", r), n, 1);
        own = 0;
        for (int i = 0; i < 4; i++) if (tbl[r].gnt[i]) own = i;
        check($sformatf("div_valid[%0d]", r), 32'(bus.div_valid), 1);
        check($sformatf("div_A[%0d]", r), bus.div_A, a_arr[own]);
        check($sformatf("div_B[%0d]", r), bus.div_B, b_arr[own]);
        bus.req = bus.req & ~tbl[r].gnt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.res_valid == 0 && n < 30);
        check($sformatf("res_valid[%0d]", r), 32'(bus.res_valid), 32'(tbl[r].gnt));
        check($sformatf("res_lat[%0d]", r), n, 9);
        check($sformatf("res[%0d]", r), bus.res, tbl[r].res);
        check($sformatf("res_inv[%0d]", r), 32'(bus.res_inv), 32'(tbl[r].inv));
        check($sformatf("timeout_err[%0d]", r), 32'(bus.timeout_err), 0);
        @(negedge clk);
        check($sformatf("busy_after[%0d]", r), 32'(bus.busy), 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_gnt"},       32'(bus.gnt), 0);
        check({nm, "_res_valid"}, 32'(bus.res_valid), 0);
        check({nm, "_busy"},      32'(bus.busy), 0);
        check({nm, "_div_valid"}, 32'(bus.div_valid), 0);
        check({nm, "_res"},       bus.res, 0);
        check({nm, "_res_inv"},   32'(bus.res_inv), 0);
        check({nm, "_div_A"},     bus.div_A, 0);
        check({nm, "_div_B"},     bus.div_B, 0);
        check({nm, "_timeout"},   32'(bus.timeout_err), 0);
    endtask

    initial begin
        int n;
        int seen;
        tbl[0]  = mk(4'b1111, {32'h90, 32'h640, 32'h300, 32'h100},
                              {32'h30, 32'h50,  32'h30,  32'h20}, 4'b0001, 32'h80, 1'b0);
        tbl[1]  = mk(4'b0000, '0, '0, 4'b0010, 32'h100, 1'b0);
        tbl[2]  = mk(4'b0000, '0, '0, 4'b0100, 32'h140, 1'b0);
        tbl[3]  = mk(4'b0000, '0, '0, 4'b1000, 32'h30,  1'b0);
        tbl[4]  = mk(4'b0001, {96'h0, 32'h100}, {96'h0, 32'h20}, 4'b0001, 32'h80, 1'b0);
        tbl[5]  = mk(4'b0100, {32'h0, 32'h200, 64'h0}, {32'h0, 32'h10, 64'h0}, 4'b0100, 32'h200, 1'b0);
        tbl[6]  = mk(4'b0101, {32'h0, 32'h40, 32'h0, 32'h50},
                              {32'h0, 32'h20, 32'h0, 32'h10}, 4'b0001, 32'h50, 1'b0);
        tbl[7]  = mk(4'b0000, '0, '0, 4'b0100, 32'h20, 1'b0);
        tbl[8]  = mk(4'b0010, {64'h0, 32'h1234, 32'h0}, '0, 4'b0010, 32'h0, 1'b1);
        tbl[9]  = mk(4'b1001, {32'h10, 64'h0, 32'h30}, {32'h10, 64'h0, 32'h8}, 4'b1000, 32'h10, 1'b0);
        tbl[10] = mk(4'b0000, '0, '0, 4'b0001, 32'h60, 1'b0);
        tbl[11] = mk(4'b0010, {64'h0, 32'h200, 32'h0}, {64'h0, 32'h40, 32'h0}, 4'b0010, 32'h80, 1'b0);

        a_arr    = '0;
        b_arr    = '0;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r <= 10; r++) run_txn(r);

        // Reset while the divide is in flight.
        a_arr[0] = 32'h100; b_arr[0] = 32'h20;
        bus.a_in = a_arr; bus.b_in = b_arr;
        bus.req  = 4'b0001;
        wait_gnt(n);
        check("midrst_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.res_valid != 0 || bus.busy) seen++;
        end
        check("midrst_no_result", seen, 0);
        run_txn(11);

        // Divider that never answers.
        model_hang = 1'b1;
        a_arr[0] = 32'h100; b_arr[0] = 32'h20;
        bus.a_in = a_arr; bus.b_in = b_arr;
        bus.req  = 4'b0001;
        wait_gnt(n);
        check("hang_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
`ifdef DIV_ARB_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.res_valid == 0 && n < 200);
        check("to_lat",       n, 64);
        check("to_err",       32'(bus.timeout_err), 1);
        check("to_res",       bus.res, 0);
        check("to_res_inv",   32'(bus.res_inv), 1);
        check("to_res_valid", 32'(bus.res_valid), 32'h1);
        @(negedge clk);
        check("to_busy_after", 32'(bus.busy), 0);
        check("to_err_pulse",  32'(bus.timeout_err), 0);
`else
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.res_valid != 0 || bus.timeout_err) seen++;
        end
        check("hang_busy",      32'(bus.busy), 1);
        check("hang_no_result", seen, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
